// File: rtl/hazard_scheduler.sv
// hazard_scheduler
//
// Hazard detection and forwarding control for a 5-stage pipeline, plus the
// sequencing FSM of a multi-cycle multiply/divide (MD) unit.
//
// Parameters
//   MD_CYCLES   MD unit latency in clocks (2..31)
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   rsd, rtd                        decode-stage source registers
//   rse, rte                        execute-stage source registers
//   writerege/m/w, regwritee/m/w    destination register and write enable per stage
//   memtorege, memtoregm            load flags in EX and MEM
//   branchd, pcsrcd                 decode branch, branch taken
//   mdstartd, mdused                decode starts an MD op / reads HI/LO
//   stallf, stalld, flushe, flushd  pipeline hold / bubble / clear controls
//   forwardad, forwardbd            branch comparator forward from MEM
//   forwardae, forwardbe            ALU operand select (00 RF, 01 WB, 10 MEM)
//   mdbusy, mddone, mdcount         MD unit status
//
// Configuration
//   BRANCH_FORWARD_EN  when defined, branch operands are forwarded from MEM
//                      instead of stalling on a MEM-stage ALU result.

module hazard_scheduler #(
    parameter int MD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsd,
    input  logic [4:0] rtd,
    input  logic [4:0] rse,
    input  logic [4:0] rte,
    input  logic [4:0] writerege,
    input  logic [4:0] writeregm,
    input  logic [4:0] writeregw,
    input  logic       regwritee,
    input  logic       regwritem,
    input  logic       regwritew,
    input  logic       memtorege,
    input  logic       memtoregm,
    input  logic       branchd,
    input  logic       pcsrcd,
    input  logic       mdstartd,
    input  logic       mdused,
    output logic       stallf,
    output logic       stalld,
    output logic       flushe,
    output logic       flushd,
    output logic       forwardad,
    output logic       forwardbd,
    output logic [1:0] forwardae,
    output logic [1:0] forwardbe,
    output logic       mdbusy,
    output logic       mddone,
    output logic [4:0] mdcount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam logic [4:0] RELOAD = 5'(MD_CYCLES - 1);

    md_state_t  state;
    md_state_t  next_state;
    logic [4:0] count;
    logic [4:0] next_count;

    logic lwstall;
    logic branchstall;
    logic mdstall;
    logic stall;
    logic mdstart_ok;
    logic ex_hit;
    logic memload_hit;

    // ALU operand forwarding: the MEM result is newer than the WB result, so
    // it wins when both stages write the same register. Register 0 is never
    // forwarded.
    always_comb begin
        forwardae = 2'b00;
        if (rse != 5'd0 && rse == writeregm && regwritem)
            forwardae = 2'b10;
        else if (rse != 5'd0 && rse == writeregw && regwritew)
            forwardae = 2'b01;

        forwardbe = 2'b00;
        if (rte != 5'd0 && rte == writeregm && regwritem)
            forwardbe = 2'b10;
        else if (rte != 5'd0 && rte == writeregw && regwritew)
            forwardbe = 2'b01;
    end

    assign lwstall = memtorege && regwritee && writerege != 5'd0 &&
                     (writerege == rsd || writerege == rtd);

    // A branch resolved in decode needs its operands now: anything still in
    // EX, or a load still in MEM, cannot be supplied in time.
    assign ex_hit      = regwritee && writerege != 5'd0 &&
                         (writerege == rsd || writerege == rtd);
    assign memload_hit = memtoregm && writeregm != 5'd0 &&
                         (writeregm == rsd || writeregm == rtd);

`ifdef BRANCH_FORWARD_EN
    assign forwardad   = rsd != 5'd0 && rsd == writeregm && regwritem;
    assign forwardbd   = rtd != 5'd0 && rtd == writeregm && regwritem;
    assign branchstall = branchd && (ex_hit || memload_hit);
`else
    // Without the MEM->decode path, any MEM-stage result the branch reads
    // must also wait a cycle.
    logic mem_hit;
    assign mem_hit     = regwritem && writeregm != 5'd0 &&
                         (writeregm == rsd || writeregm == rtd);
    assign forwardad   = 1'b0;
    assign forwardbd   = 1'b0;
    assign branchstall = branchd && (ex_hit || memload_hit || mem_hit);
`endif

    // Reading HI/LO or issuing a new MD op must wait while the unit runs.
    assign mdstall    = (state == BUSY) && (mdused || mdstartd);
    assign stall      = lwstall || branchstall || mdstall;
    assign stallf     = stall;
    assign stalld     = stall;
    assign flushe     = stall;
    assign flushd     = pcsrcd && !stall;
    assign mdstart_ok = mdstartd && !stall;

    // MD state and remaining-cycle count; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 5'd0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Next-state logic. The count is only non-zero in BUSY, so it can drive
    // mdcount directly. A start accepted in DONE reloads without an IDLE gap.
    always_comb begin
        next_state = state;
        next_count = count;
        case (state)
            IDLE: begin
                if (mdstart_ok) begin
                    next_state = BUSY;
                    next_count = RELOAD;
                end
            end
            BUSY: begin
                if (count == 5'd0) begin
                    next_state = DONE;
                    next_count = 5'd0;
                end else begin
                    next_count = count - 5'd1;
                end
            end
            DONE: begin
                if (mdstart_ok) begin
                    next_state = BUSY;
                    next_count = RELOAD;
                end else begin
                    next_state = IDLE;
                    next_count = 5'd0;
                end
            end
            default: begin
                next_state = IDLE;
                next_count = 5'd0;
            end
        endcase
    end

    assign mdbusy  = (state == BUSY);
    assign mddone  = (state == DONE);
    assign mdcount = count;

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler
//
// Scoreboard bench for hazard_scheduler. Each cycle the stimulus process
// drives inputs, computes the expected outputs from a cycle-indexed model of
// the spec rules and pushes them into a queue; a monitor pops one entry per
// cycle on the falling edge and compares it with the DUT outputs.
//
// Honors BRANCH_FORWARD_EN the same way as the design.

module tb_hazard_scheduler;

    localparam int MD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsd, rtd, rse, rte;
    logic [4:0] writerege, writeregm, writeregw;
    logic       regwritee, regwritem, regwritew;
    logic       memtorege, memtoregm;
    logic       branchd, pcsrcd, mdstartd, mdused;
    logic       stallf, stalld, flushe, flushd;
    logic       forwardad, forwardbd;
    logic [1:0] forwardae, forwardbe;
    logic       mdbusy, mddone;
    logic [4:0] mdcount;

    always #5 clk = ~clk;

    hazard_scheduler #(.MD_CYCLES(MD)) dut (
        .clk       (clk),
        .reset     (reset),
        .rsd       (rsd),
        .rtd       (rtd),
        .rse       (rse),
        .rte       (rte),
        .writerege (writerege),
        .writeregm (writeregm),
        .writeregw (writeregw),
        .regwritee (regwritee),
        .regwritem (regwritem),
        .regwritew (regwritew),
        .memtorege (memtorege),
        .memtoregm (memtoregm),
        .branchd   (branchd),
        .pcsrcd    (pcsrcd),
        .mdstartd  (mdstartd),
        .mdused    (mdused),
        .stallf    (stallf),
        .stalld    (stalld),
        .flushe    (flushe),
        .flushd    (flushd),
        .forwardad (forwardad),
        .forwardbd (forwardbd),
        .forwardae (forwardae),
        .forwardbe (forwardbe),
        .mdbusy    (mdbusy),
        .mddone    (mddone),
        .mdcount   (mdcount)
    );

    typedef struct packed {
        logic       reset;
        logic [4:0] rsd, rtd, rse, rte;
        logic [4:0] writerege, writeregm, writeregw;
        logic       regwritee, regwritem, regwritew;
        logic       memtorege, memtoregm;
        logic       branchd, pcsrcd, mdstartd, mdused;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic       flushd;
        logic       fad, fbd;
        logic [1:0] fae, fbe;
        logic       mdbusy, mddone;
        logic [4:0] mdcount;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_start = -1000;

    function automatic logic [1:0] fwd(input logic [4:0] src, input stim_t st);
        if (src == 5'd0) return 2'b00;
        if (st.regwritem && src == st.writeregm) return 2'b10;
        if (st.regwritew && src == st.writeregw) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit reads(input logic en, input logic [4:0] dst, input stim_t st);
        return en && dst != 5'd0 && (dst == st.rsd || dst == st.rtd);
    endfunction

    // Outputs in cycle c given the cycle s of the last accepted MD start:
    // busy for cycles s+1..s+MD, done in cycle s+MD+1.
    function automatic exp_t model(input stim_t st, input int c, input int s);
        exp_t e;
        bit   busy, lw, br, mds, stall;
        busy = (c > s) && (c <= s + MD);
        e.mdbusy  = busy;
        e.mddone  = (c == s + MD + 1);
        e.mdcount = busy ? 5'(s + MD - c) : 5'd0;
        lw  = st.memtorege && reads(st.regwritee, st.writerege, st);
        br  = st.branchd && (reads(st.regwritee, st.writerege, st) ||
                             reads(st.memtoregm, st.writeregm, st));
`ifdef BRANCH_FORWARD_EN
        e.fad = st.rsd != 5'd0 && st.rsd == st.writeregm && st.regwritem;
        e.fbd = st.rtd != 5'd0 && st.rtd == st.writeregm && st.regwritem;
`else
        e.fad = 1'b0;
        e.fbd = 1'b0;
        br  = br || (st.branchd && reads(st.regwritem, st.writeregm, st));
`endif
        mds   = busy && (st.mdused || st.mdstartd);
        stall = lw || br || mds;
        e.stall  = stall;
        e.flushd = st.pcsrcd && !stall;
        e.fae    = fwd(st.rse, st);
        e.fbe    = fwd(st.rte, st);
        return e;
    endfunction

    task automatic applyStimulus(input stim_t st);
        exp_t e;
        e = model(st, cyc, last_start);
        reset     = st.reset;
        rsd       = st.rsd;
        rtd       = st.rtd;
        rse       = st.rse;
        rte       = st.rte;
        writerege = st.writerege;
        writeregm = st.writeregm;
        writeregw = st.writeregw;
        regwritee = st.regwritee;
        regwritem = st.regwritem;
        regwritew = st.regwritew;
        memtorege = st.memtorege;
        memtoregm = st.memtoregm;
        branchd   = st.branchd;
        pcsrcd    = st.pcsrcd;
        mdstartd  = st.mdstartd;
        mdused    = st.mdused;
        expq.push_back(e);
        if (st.reset)
            last_start = -1000;
        else if (st.mdstartd && !e.stall)
            last_start = cyc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check1("stallf",    {4'b0, stallf},    {4'b0, e.stall});
        check1("stalld",    {4'b0, stalld},    {4'b0, e.stall});
        check1("flushe",    {4'b0, flushe},    {4'b0, e.stall});
        check1("flushd",    {4'b0, flushd},    {4'b0, e.flushd});
        check1("forwardad", {4'b0, forwardad}, {4'b0, e.fad});
        check1("forwardbd", {4'b0, forwardbd}, {4'b0, e.fbd});
        check1("forwardae", {3'b0, forwardae}, {3'b0, e.fae});
        check1("forwardbe", {3'b0, forwardbe}, {3'b0, e.fbe});
        check1("mdbusy",    {4'b0, mdbusy},    {4'b0, e.mdbusy});
        check1("mddone",    {4'b0, mddone},    {4'b0, e.mddone});
        check1("mdcount",   mdcount,           e.mdcount);
    endtask

    // Monitor: one expected entry per cycle, compared away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput(e);
        end
    end

    function automatic logic [4:0] pickReg();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        stim_t s;
        int    guard;

        s = '0;
        s.reset = 1'b1;
        reset = 1'b1;
        {rsd, rtd, rse, rte, writerege, writeregm, writeregw} = '0;
        {regwritee, regwritem, regwritew, memtorege, memtoregm} = '0;
        {branchd, pcsrcd, mdstartd, mdused} = '0;
        @(posedge clk);
        #1;

        $display("[TB] reset state");
        applyStimulus(s);
        applyStimulus(s);

        $display("[TB] load-use");
        s = '0;
        s.memtorege = 1'b1; s.regwritee = 1'b1; s.writerege = 5'd5; s.rsd = 5'd5;
        applyStimulus(s);
        s.rsd = 5'd6;
        applyStimulus(s);

        $display("[TB] forward priority");
        s = '0;
        s.rse = 5'd3; s.writeregm = 5'd3; s.writeregw = 5'd3;
        s.regwritem = 1'b1; s.regwritew = 1'b1;
        applyStimulus(s);
        s.regwritem = 1'b0;
        applyStimulus(s);
        s.rse = 5'd0;
        applyStimulus(s);

        $display("[TB] MD timing");
        s = '0;
        s.mdstartd = 1'b1;
        applyStimulus(s);
        s = '0;
        s.mdused = 1'b1;
        for (int i = 0; i < MD; i++) applyStimulus(s);
        s = '0;
        applyStimulus(s);
        applyStimulus(s);

        $display("[TB] back-to-back MD");
        s = '0;
        s.mdstartd = 1'b1;
        for (int i = 0; i < MD + 3; i++) applyStimulus(s);
        s = '0;
        for (int i = 0; i < MD + 2; i++) applyStimulus(s);

        $display("[TB] reset mid-op");
        s = '0;
        s.mdstartd = 1'b1;
        applyStimulus(s);
        s = '0;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        s.reset = 1'b1;
        applyStimulus(s);
        s = '0;
        for (int i = 0; i < MD + 4; i++) applyStimulus(s);

        $display("[TB] branch");
        s = '0;
        s.branchd = 1'b1; s.rsd = 5'd7; s.writeregm = 5'd7; s.regwritem = 1'b1;
        applyStimulus(s);
        s.pcsrcd = 1'b1;
        applyStimulus(s);
        s = '0;
        s.branchd = 1'b1; s.pcsrcd = 1'b1; s.rsd = 5'd9;
        applyStimulus(s);

        $display("[TB] random");
        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.reset     = ($urandom_range(0, 79) == 0);
            s.rsd       = pickReg();
            s.rtd       = pickReg();
            s.rse       = pickReg();
            s.rte       = pickReg();
            s.writerege = pickReg();
            s.writeregm = pickReg();
            s.writeregw = pickReg();
            s.regwritee = 1'($urandom_range(0, 1));
            s.regwritem = 1'($urandom_range(0, 1));
            s.regwritew = 1'($urandom_range(0, 1));
            s.memtorege = ($urandom_range(0, 2) == 0);
            s.memtoregm = ($urandom_range(0, 2) == 0);
            s.branchd   = ($urandom_range(0, 2) == 0);
            s.pcsrcd    = 1'($urandom_range(0, 1));
            s.mdstartd  = ($urandom_range(0, 5) == 0);
            s.mdused    = ($urandom_range(0, 4) == 0);
            applyStimulus(s);
        end

        guard = 0;
        while (expq.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #2;
        if (expq.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain actual=%0d required=0", expq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 Parameter MD_CYCLES, default 8, latency of the multi-cycle multiply/divide unit in clocks (legal range 2..31).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rsd, rtd  input  5 each  decode-stage source register numbers.
REQ-005 rse, rte  input  5 each  execute-stage source register numbers.
REQ-006 writerege, writeregm, writeregw  input  5 each  destination register in EX, MEM and WB stages.
REQ-007 regwritee, regwritem, regwritew  input  1 each  register-write enables in EX, MEM and WB stages.
REQ-008 memtorege, memtoregm  input  1 each  load flag in EX and MEM stages.
REQ-009 branchd, pcsrcd  input  1 each  decode instruction is a branch; branch taken.
REQ-010 mdstartd, mdused  input  1 each  decode instruction starts an MD operation; decode instruction reads the MD result (HI/LO).
REQ-011 stallf, stalld, flushe, flushd  output  1 each  hold PC, hold IF/ID, bubble ID/EX, clear IF/ID.
REQ-012 forwardad, forwardbd  output  1 each  decode comparator operand forward select from MEM.
REQ-013 forwardae, forwardbe  output  2 each  ALU operand select: 00 register file, 01 WB result, 10 MEM result.
REQ-014 mdbusy, mddone  output  1 each  MD unit running; one-cycle completion pulse.
REQ-015 mdcount  output  5  remaining MD cycles.

Function
REQ-016 forwardae SHALL be 10 when rse!=0, rse==writeregm and regwritem; else 01 when rse!=0, rse==writeregw and regwritew; else 00; forwardbe identically using rte; MEM takes priority over WB.
REQ-017 lwstall SHALL be asserted when memtorege, regwritee, writerege!=0 and writerege equals rsd or rtd.
REQ-018 branchstall SHALL be asserted when branchd and either (regwritee, writerege!=0, writerege in {rsd,rtd}) or (memtoregm, writeregm!=0, writeregm in {rsd,rtd}).
REQ-019 mdstall SHALL be asserted when mdused or mdstartd while the FSM is BUSY.
REQ-020 stallf=stalld=flushe=lwstall|branchstall|mdstall, all combinational, same-cycle.
REQ-021 flushd SHALL be pcsrcd & ~stalld.
REQ-022 MD FSM states: IDLE, BUSY, DONE; the FSM SHALL start an operation only when mdstartd & ~stalld.
REQ-023 IDLE: an accepted start SHALL go to BUSY with mdcount=MD_CYCLES-1.
REQ-024 BUSY: mdcount SHALL decrement every cycle; at mdcount==0, next state SHALL be DONE.
REQ-025 DONE: lasts exactly one cycle; an accepted start in DONE SHALL go directly to BUSY (count reloaded), otherwise IDLE.
REQ-026 mdbusy SHALL be 1 exactly in BUSY, mddone exactly in DONE; mdcount SHALL be 0 outside BUSY.
REQ-027 Start to mddone SHALL be MD_CYCLES+1 clocks (mdbusy high MD_CYCLES cycles).
REQ-028 Register 0 SHALL never cause a forward or a stall.

Reset
REQ-029 With reset high at a clock edge, the FSM SHALL enter IDLE, mdcount=0, mdbusy=0, mddone=0, aborting any MD operation in flight.
REQ-030 Combinational hazard outputs SHALL depend only on current inputs and FSM state, and SHALL therefore be 0 after reset unless current inputs demand otherwise.

Configuration
REQ-031 Macro BRANCH_FORWARD_EN: when defined, forwardad=(rsd!=0 & rsd==writeregm & regwritem) and forwardbd likewise using rtd.
REQ-032 Without BRANCH_FORWARD_EN: forwardad=forwardbd=0, and branchstall additionally SHALL assert when branchd, regwritem, writeregm!=0 and writeregm in {rsd,rtd}.

Verification
REQ-033 Load-use: memtorege=1, regwritee=1, writerege=5, rsd=5 -> stallf=stalld=flushe=1 same cycle; rsd=6 -> all 0.
REQ-034 Forward priority: rse=3, writeregm=writeregw=3, regwritem=regwritew=1 -> forwardae=10; regwritem=0 -> 01; rse=0 -> 00.
REQ-035 MD timing (MD_CYCLES=8): mdstartd pulse at cycle 0 -> mdbusy cycles 1-8, mdcount 7..0, mddone cycle 9; mdused during cycles 1-8 -> stalld=1.
REQ-036 Back-to-back MD: mdstartd held in DONE cycle -> BUSY next cycle with mdcount=7, no IDLE cycle; mdstartd during BUSY -> stalld=1 and no restart.
REQ-037 Reset mid-op: reset at mdcount=4 -> next cycle IDLE, mdbusy=0, mdcount=0, mddone never pulses.
REQ-038 Branch: branchd=1, rsd=7, writeregm=7, regwritem=1, memtoregm=0 -> with BRANCH_FORWARD_EN forwardad=1, stalld=0; without it stalld=1; pcsrcd=1 with stalld=0 -> flushd=1.
